// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard controller for the 5-stage core.
// Drives per-stage load/bubble vectors and the PC jump, and keeps debug counters.
//
// Ports:
//   clk, rstn          core clock, async active-low reset
//   mem_busy_i         data memory not ready (MEM holds)
//   ex_busy_i          multi-cycle EX op in progress
//   ld_use_i           load-use hazard seen in ID
//   jump_i/jump_addr_i taken branch/jump resolved in EX and its target
//   cnt_clr_i          synchronous clear of both counters
//   hold_en_o          per-stage load enable [0]pc [1]if_id [2]id_ex [3]ex_mem [4]mem_wb
//   flush_o            per-stage bubble insert (same bit order)
//   pc_jump_o          PC loads pc_jump_addr_o this cycle
//   pc_jump_addr_o     jump target to the PC
//   stall_cnt_o        saturating count of cycles with the PC held
//   flush_cnt_o        saturating count of applied jumps
module pipe_ctrl #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              mem_busy_i,
    input  logic              ex_busy_i,
    input  logic              ld_use_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              cnt_clr_i,
    output logic [4:0]        hold_en_o,
    output logic [4:0]        flush_o,
    output logic              pc_jump_o,
    output logic [ADDR_W-1:0] pc_jump_addr_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        STALL_JP = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] jp_addr_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;

    logic busy;
    logic pend_jp;
    logic jump_apply;

    assign busy    = mem_busy_i | ex_busy_i;
    assign pend_jp = (state_q == STALL_JP);

    // A pending jump belongs to the same EX instruction still presenting
    // jump_i, so it takes the place of any new jump request.
    assign jump_apply = !busy && (pend_jp || jump_i);

    assign pc_jump_addr_o = pend_jp ? jp_addr_q : jump_addr_i;

    always_comb begin
        hold_en_o = 5'b11111;
        flush_o   = 5'b00000;
        pc_jump_o = 1'b0;
        priority case (1'b1)
            mem_busy_i: begin
                hold_en_o = 5'b10000;
                flush_o   = 5'b10000;
            end
            ex_busy_i: begin
                hold_en_o = 5'b11000;
                flush_o   = 5'b01000;
            end
            jump_apply: begin
                hold_en_o = 5'b11111;
                flush_o   = 5'b00110;
                pc_jump_o = 1'b1;
            end
            ld_use_i: begin
                hold_en_o = 5'b11100;
                flush_o   = 5'b00100;
            end
            default: begin
                hold_en_o = 5'b11111;
                flush_o   = 5'b00000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= RUN;
            jp_addr_q <= '0;
        end else begin
            unique case (state_q)
                RUN, STALL: begin
                    if (busy && jump_i) begin
                        state_q   <= STALL_JP;
                        jp_addr_q <= jump_addr_i;
                    end else if (busy) begin
                        state_q <= STALL;
                    end else begin
                        state_q <= RUN;
                    end
                end
                STALL_JP: begin
                    if (!busy) begin
                        state_q <= RUN;
                    end
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (cnt_clr_i) begin
                stall_cnt_q <= '0;
            end else if (!hold_en_o[0] && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (cnt_clr_i) begin
                flush_cnt_q <= '0;
            end else if (pc_jump_o && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and random checks of pipe_ctrl
// against a rule-level reference model.
module tb_pipe_ctrl;

    logic        clk;
    logic        rstn;
    logic        mem_busy;
    logic        ex_busy;
    logic        ld_use;
    logic        jump;
    logic [31:0] jump_addr;
    logic        cnt_clr;
    logic [4:0]  hold_en;
    logic [4:0]  flush;
    logic        pc_jump;
    logic [31:0] pc_jump_addr;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int total;
    int passed;

    // reference model state: pending jump target queue and counters
    logic [31:0] pq[$];
    int          m_stall;
    int          m_flush;

    pipe_ctrl #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .mem_busy_i     (mem_busy),
        .ex_busy_i      (ex_busy),
        .ld_use_i       (ld_use),
        .jump_i         (jump),
        .jump_addr_i    (jump_addr),
        .cnt_clr_i      (cnt_clr),
        .hold_en_o      (hold_en),
        .flush_o        (flush),
        .pc_jump_o      (pc_jump),
        .pc_jump_addr_o (pc_jump_addr),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // One clock: outputs checked at negedge, counters after posedge.
    task automatic step(input bit chk);
        logic [4:0]  eh;
        logic [4:0]  ef;
        logic [31:0] ea;
        bit          busy;
        bit          pend;
        bit          apply;
        @(negedge clk);
        busy  = mem_busy || ex_busy;
        pend  = (pq.size() > 0);
        apply = !busy && (pend || jump);
        ea    = pend ? pq[0] : jump_addr;
        if (mem_busy) begin
            eh = 5'b10000; ef = 5'b10000;
        end else if (ex_busy) begin
            eh = 5'b11000; ef = 5'b01000;
        end else if (apply) begin
            eh = 5'b11111; ef = 5'b00110;
        end else if (ld_use) begin
            eh = 5'b11100; ef = 5'b00100;
        end else begin
            eh = 5'b11111; ef = 5'b00000;
        end
        if (chk) begin
            check("hold_en", 64'(hold_en), 64'(eh));
            check("flush", 64'(flush), 64'(ef));
            check("pc_jump", 64'(pc_jump), 64'(apply));
            check("pc_jump_addr", 64'(pc_jump_addr), 64'(ea));
        end
        if (apply) pq.delete();
        else if (busy && jump && !pend) pq.push_back(jump_addr);
        if (cnt_clr) m_stall = 0;
        else if (!eh[0] && m_stall < 65535) m_stall++;
        if (cnt_clr) m_flush = 0;
        else if (apply && m_flush < 65535) m_flush++;
        @(posedge clk);
        #1;
        if (chk) begin
            check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
            check("flush_cnt", 64'(flush_cnt), 64'(m_flush));
        end
    endtask

    task automatic set_in(input logic mb, input logic eb, input logic lu,
                          input logic jp, input logic [31:0] ja,
                          input logic cc);
        mem_busy  = mb;
        ex_busy   = eb;
        ld_use    = lu;
        jump      = jp;
        jump_addr = ja;
        cnt_clr   = cc;
    endtask

    initial begin
        total   = 0;
        passed  = 0;
        m_stall = 0;
        m_flush = 0;
        rstn    = 1'b0;
        set_in(0, 0, 0, 0, 32'h0, 0);
        #12;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // idle after reset
        check("rst_hold", 64'(hold_en), 64'h1F);
        check("rst_pc_jump_addr", 64'(pc_jump_addr), 64'h0);
        for (int i = 0; i < 3; i++) step(1);

        // load-use single cycle
        set_in(0, 0, 1, 0, 32'h0, 0);
        step(1);
        set_in(0, 0, 0, 0, 32'h0, 0);
        step(1);

        // jump overrides load-use
        set_in(0, 0, 1, 1, 32'h100, 0);
        step(1);
        set_in(0, 0, 0, 0, 32'h0, 0);
        step(1);

        // jump held through ex_busy; target changes mid-stall
        for (int i = 0; i < 4; i++) begin
            set_in(0, 1, 0, 1, (i >= 2) ? 32'h300 : 32'h200, 0);
            step(1);
        end
        set_in(0, 0, 0, 1, 32'h300, 0);
        step(1);
        set_in(0, 0, 0, 0, 32'h0, 0);
        step(1);
        check("jp_once_flush_cnt", 64'(flush_cnt), 64'd2);

        // both busy: mem_busy vector wins
        set_in(1, 1, 1, 0, 32'h0, 0);
        step(1);
        step(1);

        // capture jump during stall, then reset drops it
        set_in(1, 0, 0, 1, 32'h400, 0);
        step(1);
        step(1);
        rstn = 1'b0;
        #2;
        pq.delete();
        m_stall = 0;
        m_flush = 0;
        set_in(0, 0, 0, 0, 32'h0, 0);
        #1;
        rstn = 1'b1;
        check("post_rst_stall_cnt", 64'(stall_cnt), 64'h0);
        check("post_rst_flush_cnt", 64'(flush_cnt), 64'h0);
        step(1);
        step(1);

        // clear coincident with increment
        set_in(0, 1, 0, 0, 32'h0, 1);
        step(1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 5) == 0,
                   $urandom_range(0, 4) == 0,
                   $urandom_range(0, 3) == 0,
                   $urandom_range(0, 2) == 0,
                   $urandom,
                   $urandom_range(0, 30) == 0);
            step(1);
        end

        // stall counter saturation
        set_in(1, 0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 65536 + 5; i++) step(0);
        check("stall_sat", 64'(stall_cnt), 64'hFFFF);
        step(1);
        set_in(0, 0, 0, 0, 32'h0, 1);
        step(1);
        check("stall_clr", 64'(stall_cnt), 64'h0);
        set_in(0, 0, 0, 0, 32'h0, 0);
        step(1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
